// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, runs a req/ack instruction-memory read per
// enable_IF, defers mid-fetch PC writes to the ack edge. Optional macro: IF_ALIGN_CHECK_EN.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_IF,
    input  logic        pc_wr,
    input  logic [1:0]  PCsrc,
    input  logic [15:0] BTarget,
    input  logic [15:0] jumpTarget,
    input  logic [15:0] retAddr,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic [15:0] PC,
    output logic [15:0] instruction,
    output logic [15:0] nextPC,
    output logic        fetch_done,
    output logic        busy,
    output logic        misalign
);

    typedef enum logic { IDLE = 1'b0, WAIT = 1'b1 } state_t;

    state_t      state_q;
    logic [15:0] pc_q, instr_q, npc_q, addr_q, pend_q;
    logic        pend_vld_q, req_q, busy_q, done_q, mis_q;
    logic [15:0] sel, sel_w;
    logic        wr_ok, mis_set;

    always_comb begin
        sel = npc_q;
        case (PCsrc)
            2'b00: sel = npc_q;
            2'b01: sel = BTarget;
            2'b10: sel = jumpTarget;
            2'b11: sel = retAddr;
            default: sel = npc_q;
        endcase
    end

`ifdef IF_ALIGN_CHECK_EN
    // Odd targets are dropped entirely and flagged until reset.
    assign wr_ok   = pc_wr & ~sel[0];
    assign mis_set = pc_wr & sel[0];
    assign sel_w   = sel;
`else
    assign wr_ok   = pc_wr;
    assign mis_set = 1'b0;
    assign sel_w   = sel & 16'hFFFE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            npc_q      <= '0;
            addr_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (mis_set) mis_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (wr_ok) pc_q <= sel_w;
                    if (enable_IF) begin
                        addr_q  <= wr_ok ? sel_w : pc_q;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        npc_q      <= addr_q + 16'd2;
                        req_q      <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pend_vld_q <= 1'b0;
                        state_q    <= IDLE;
                        // A write on the ack cycle itself wins over anything pending.
                        if (wr_ok)           pc_q <= sel_w;
                        else if (pend_vld_q) pc_q <= pend_q;
                    end else if (wr_ok) begin
                        pend_q     <= sel_w;
                        pend_vld_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign PC          = pc_q;
    assign instruction = instr_q;
    assign nextPC      = npc_q;
    assign fetch_done  = done_q;
    assign busy        = busy_q;
    assign misalign    = mis_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: inputs change 1ns after a rising edge, outputs sampled there too.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_IF, pc_wr, imem_ack;
    logic [1:0]  PCsrc;
    logic [15:0] BTarget, jumpTarget, retAddr, imem_rdata;
    logic        imem_req, fetch_done, busy, misalign;
    logic [15:0] imem_addr, PC, instruction, nextPC;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .enable_IF(enable_IF), .pc_wr(pc_wr), .PCsrc(PCsrc),
        .BTarget(BTarget), .jumpTarget(jumpTarget), .retAddr(retAddr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .PC(PC), .instruction(instruction), .nextPC(nextPC), .fetch_done(fetch_done),
        .busy(busy), .misalign(misalign)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable_IF = 0; pc_wr = 0; imem_ack = 0; PCsrc = 2'b00;
        BTarget = 0; jumpTarget = 0; retAddr = 0; imem_rdata = 0;
        step(); step();
        checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", PC); end
        checks++; if ({imem_req, fetch_done, busy, misalign} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags got %b exp 0000", {imem_req, fetch_done, busy, misalign}); end
        checks++; if ({instruction, nextPC, imem_addr} !== 48'h0) begin errors++;
            $display("FAIL reset_regs got %h exp 0", {instruction, nextPC, imem_addr}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero_wait();
        enable_IF = 1; step(); enable_IF = 0;
        checks++; if ({imem_req, busy, fetch_done} !== 3'b110) begin errors++;
            $display("FAIL zw_req got %b exp 110", {imem_req, busy, fetch_done}); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL zw_addr got %h exp 0000", imem_addr); end
        imem_ack = 1; imem_rdata = 16'h3A41; step(); imem_ack = 0;
        checks++; if ({fetch_done, imem_req, busy} !== 3'b100) begin errors++;
            $display("FAIL zw_done got %b exp 100", {fetch_done, imem_req, busy}); end
        checks++; if (instruction !== 16'h3A41) begin errors++; $display("FAIL zw_instr got %h exp 3a41", instruction); end
        checks++; if (nextPC !== 16'h0002) begin errors++; $display("FAIL zw_npc got %h exp 0002", nextPC); end
        imem_rdata = 16'hDEAD; step();
        checks++; if (fetch_done !== 1'b0 || instruction !== 16'h3A41) begin errors++;
            $display("FAIL zw_pulse got %b/%h exp 0/3a41", fetch_done, instruction); end
    endtask

    task automatic test_jump_waits();
        pc_wr = 1; PCsrc = 2'b10; jumpTarget = 16'h0400; enable_IF = 1;
        step(); pc_wr = 0; enable_IF = 0;
        checks++; if (imem_addr !== 16'h0400 || PC !== 16'h0400) begin errors++;
            $display("FAIL jmp_addr got %h/%h exp 0400/0400", imem_addr, PC); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (fetch_done !== 1'b0 || imem_req !== 1'b1) begin errors++;
                $display("FAIL jmp_wait%0d got %b%b exp 01", i, fetch_done, imem_req); end
        end
        imem_ack = 1; imem_rdata = 16'h1234; step(); imem_ack = 0;
        checks++; if (fetch_done !== 1'b1 || nextPC !== 16'h0402 || instruction !== 16'h1234) begin errors++;
            $display("FAIL jmp_done got %b/%h/%h exp 1/0402/1234", fetch_done, nextPC, instruction); end
        step();
    endtask

    task automatic test_deferred();
        pc_wr = 1; PCsrc = 2'b01; BTarget = 16'h0010; step(); pc_wr = 0;
        checks++; if (PC !== 16'h0010) begin errors++; $display("FAIL def_setup got %h exp 0010", PC); end
        enable_IF = 1; step(); enable_IF = 0;
        pc_wr = 1; BTarget = 16'h0120; step(); pc_wr = 0;
        checks++; if (PC !== 16'h0010) begin errors++; $display("FAIL def_hold got %h exp 0010", PC); end
        step();
        checks++; if (PC !== 16'h0010) begin errors++; $display("FAIL def_hold2 got %h exp 0010", PC); end
        imem_ack = 1; step(); imem_ack = 0;
        checks++; if (PC !== 16'h0120 || nextPC !== 16'h0012) begin errors++;
            $display("FAIL def_apply got %h/%h exp 0120/0012", PC, nextPC); end
        step();
        // Pending write then a direct write on the ack cycle: the direct one wins.
        enable_IF = 1; step(); enable_IF = 0;
        pc_wr = 1; PCsrc = 2'b01; BTarget = 16'h0200; step();
        PCsrc = 2'b10; jumpTarget = 16'h0300; imem_ack = 1; step(); pc_wr = 0; imem_ack = 0;
        checks++; if (PC !== 16'h0300) begin errors++; $display("FAIL def_override got %h exp 0300", PC); end
        step();
    endtask

    task automatic test_wrap();
        pc_wr = 1; PCsrc = 2'b01; BTarget = 16'hFFFE; step(); pc_wr = 0;
        checks++; if (PC !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc got %h exp fffe", PC); end
        enable_IF = 1; step(); enable_IF = 0;
        checks++; if (imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr got %h exp fffe", imem_addr); end
        imem_ack = 1; step(); imem_ack = 0;
        checks++; if (nextPC !== 16'h0000) begin errors++; $display("FAIL wrap_npc got %h exp 0000", nextPC); end
        pc_wr = 1; PCsrc = 2'b00; step(); pc_wr = 0;
        checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL wrap_seq got %h exp 0000", PC); end
        step();
    endtask

    task automatic test_reset_midfetch();
        enable_IF = 1; step(); enable_IF = 0;
        step();
        rst_n = 1'b0; #1;
        checks++; if ({imem_req, busy} !== 2'b00) begin errors++;
            $display("FAIL rst_async got %b exp 00", {imem_req, busy}); end
        step(); rst_n = 1'b1;
        imem_ack = 1; imem_rdata = 16'hBEEF; step(); imem_ack = 0;
        checks++; if ({fetch_done, imem_req, busy} !== 3'b000 || instruction !== 16'h0000) begin errors++;
            $display("FAIL rst_lateack got %b/%h exp 000/0000", {fetch_done, imem_req, busy}, instruction); end
        step();
    endtask

    task automatic test_align();
        pc_wr = 1; PCsrc = 2'b11; retAddr = 16'h0205; step(); pc_wr = 0;
`ifdef IF_ALIGN_CHECK_EN
        checks++; if (PC !== 16'h0000 || misalign !== 1'b1) begin errors++;
            $display("FAIL align got %h/%b exp 0000/1", PC, misalign); end
`else
        checks++; if (PC !== 16'h0204 || misalign !== 1'b0) begin errors++;
            $display("FAIL align got %h/%b exp 0204/0", PC, misalign); end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_jump_waits();
        test_deferred();
        test_wrap();
        test_reset_midfetch();
        test_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit multi-cycle RISC processor; sits directly upstream of the decode stage and supplies its `instruction` and `nextPC` inputs. Holds the architectural PC, fetches one instruction per `enable_IF` request over a req/ack instruction-memory handshake, and updates the PC from the sequential, branch, jump or return target selected by the control unit. PC writes arriving mid-fetch are deferred and applied when the fetch completes.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset (bit 0 must be 0).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `enable_IF`  in  1  control-unit request to fetch at current PC.
- `pc_wr`  in  1  commit a PC update this cycle.
- `PCsrc`  in  2  PC source: 00 nextPC, 01 BTarget, 10 jumpTarget, 11 retAddr.
- `BTarget`  in  16  branch target from decode.
- `jumpTarget`  in  16  jump target from decode.
- `retAddr`  in  16  return address (register-file BusA).
- `imem_req`  out  1  instruction-memory read request.
- `imem_addr`  out  16  read address, stable while `imem_req` high.
- `imem_rdata`  in  16  read data, valid with `imem_ack`.
- `imem_ack`  in  1  read complete.
- `PC`  out  16  architectural PC.
- `instruction`  out  16  last fetched instruction.
- `nextPC`  out  16  fetch address + 2 of last fetch.
- `fetch_done`  out  1  one-cycle pulse, `instruction`/`nextPC` just updated.
- `busy`  out  1  fetch in progress.
- `misalign`  out  1  sticky odd-target flag (see Configuration).

## Operation
- Reset: `PC`=RESET_PC, `instruction`=0, `nextPC`=0, `imem_addr`=0, pending cleared; `imem_req`, `fetch_done`, `busy`, `misalign`=0; state IDLE.
- Target mux `sel`: by `PCsrc`; source 00 uses registered `nextPC`.
- FSM states: IDLE, WAIT.
- IDLE: `pc_wr` → `PC`<=`sel`. `enable_IF` → `imem_addr`<=(`pc_wr` ? `sel` : `PC`), `imem_req`<=1, `busy`<=1, go WAIT. Both together: PC updated and fetch uses new value.
- WAIT: `enable_IF` ignored. `imem_ack`=1 → `instruction`<=`imem_rdata`, `nextPC`<=`imem_addr`+2 (mod 2^16, FFFE→0000), `imem_req`<=0, `busy`<=0, `fetch_done`<=1, go IDLE.
- `pc_wr` in WAIT: `sel` captured into pending register (later write overwrites earlier); applied to `PC` on the ack edge. `pc_wr` on the ack cycle itself applies directly, overriding pending.
- `imem_ack` outside WAIT ignored.
- `rst_n` low mid-fetch: `imem_req` drops immediately; a late ack after reset release is ignored.

## Timing
- `imem_req` registered: high first cycle after `enable_IF` sampled.
- Zero-wait ack (ack in first req cycle) allowed: `enable_IF` at edge t → `fetch_done` high cycle t+2; each extra wait cycle adds one.
- `fetch_done` exactly one cycle; `instruction`/`nextPC` hold until next completed fetch.
- `PC` update visible the cycle after the sampling edge of `pc_wr` (IDLE) or of the ack (deferred).

## Configuration
- `IF_ALIGN_CHECK_EN` defined: a PC write whose `sel`[0]=1 is discarded (PC unchanged, pending not loaded) and sets `misalign`, which stays high until reset.
- Not defined: `sel`[0] forced to 0 on every write; `misalign` tied 0.

## Test plan
- Reset, then `enable_IF` with ack in first req cycle, `imem_rdata`=16'h3A41 → `imem_addr`=0000, `fetch_done` at t+2, `instruction`=3A41, `nextPC`=0002.
- `pc_wr`, `PCsrc`=10, `jumpTarget`=0x0400, same cycle as `enable_IF`, ack after 3 waits → `imem_addr`=0400, `nextPC`=0402, `fetch_done` at t+5.
- `pc_wr`, `PCsrc`=01, `BTarget`=0x0120 during WAIT at 0x0010 → `PC` stays 0x0010 until ack edge, then 0x0120; `nextPC`=0x0012.
- `PC`=FFFE, fetch → `nextPC`=0000; then `pc_wr` `PCsrc`=00 → `PC`=0000.
- `rst_n` low two cycles into WAIT, ack arrives after release → `imem_req`=0, `busy`=0, `instruction`=0, no `fetch_done`.
- `PCsrc`=11, `retAddr`=0x0205: with `IF_ALIGN_CHECK_EN`, `PC` unchanged, `misalign`=1; without, `PC`=0x0204, `misalign`=0.
